// File: rtl/ads7950_spi_responder_if.sv
// SPI link between the host-side master and the ADS7950 responder model.
// Signals: sclk/ss/mosi are driven by the master, miso by the responder.
// Modports: master (drives the bus), slave (the ADC-side responder).
interface ads7950_spi_responder_if;
  logic sclk;
  logic ss;
  logic mosi;
  logic miso;

  modport master (output sclk, output ss, output mosi, input miso);
  modport slave  (input sclk, input ss, input mosi, output miso);
endinterface

// File: rtl/ads7950_spi_responder.sv
// ADS7950 4-channel 12-bit ADC stand-in on the FPGA side of an SPI loopback.
// Ports: clk/rst (async active-low), spi (slave modport), chan_data (per-channel
//   values), last_cmd/frame_count/prog_ch (decoded status), frame_err (abort pulse).
// A command in frame N programs the channel captured at frame N+1 and shifted out in N+2.
module ads7950_spi_responder #(
  parameter int NCH = 4,
  parameter int DW  = 12
) (
  input  logic                clk,
  input  logic                rst,
  ads7950_spi_responder_if.slave spi,
  input  logic [NCH*DW-1:0]   chan_data,
  output logic [15:0]         last_cmd,
  output logic [15:0]         frame_count,
  output logic                frame_err,
  output logic [1:0]          prog_ch
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state;
  logic [4:0]  bcnt;
  logic [15:0] shift_in;
  logic [15:0] shift_out;
  logic [15:0] held_word;
  logic        miso_reg;

  // Two-flop synchronizers plus one delay stage for edge detection.
  // They reset low so a reset released while ss is already low never
  // fabricates a falling edge: the interrupted frame stays silent.
  logic [1:0] sclk_s;
  logic [1:0] ss_s;
  logic [1:0] mosi_s;
  logic       sclk_d;
  logic       ss_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_s <= 2'b00;
      ss_s   <= 2'b00;
      mosi_s <= 2'b00;
      sclk_d <= 1'b0;
      ss_d   <= 1'b0;
    end else begin
      sclk_s <= {sclk_s[0], spi.sclk};
      ss_s   <= {ss_s[0], spi.ss};
      mosi_s <= {mosi_s[0], spi.mosi};
      sclk_d <= sclk_s[1];
      ss_d   <= ss_s[1];
    end
  end

  logic sclk_rise;
  logic sclk_fall;
  logic ss_rise;
  logic ss_fall;

  assign sclk_rise = sclk_s[1] & ~sclk_d;
  assign sclk_fall = ~sclk_s[1] & sclk_d;
  assign ss_rise   = ss_s[1] & ~ss_d;
  assign ss_fall   = ~ss_s[1] & ss_d;

  // Conversion value of the currently programmed channel.
  logic [DW-1:0] cap_dat;
  assign cap_dat = chan_data[int'(prog_ch)*DW +: DW];

  assign spi.miso = miso_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      bcnt        <= 5'd0;
      shift_in    <= 16'h0000;
      shift_out   <= 16'h0000;
      held_word   <= 16'h0000;
      miso_reg    <= 1'b0;
      last_cmd    <= 16'h0000;
      frame_count <= 16'h0000;
      frame_err   <= 1'b0;
      prog_ch     <= 2'd0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (ss_fall) begin
            // Shift out the previous capture and take a new one now.
            shift_out <= held_word;
            held_word <= {2'b00, prog_ch, cap_dat};
            miso_reg  <= held_word[15];
            bcnt      <= 5'd0;
            state     <= SHIFT;
          end
        end

        SHIFT: begin
          // ss rising wins over a coincident sclk edge.
          if (ss_rise) begin
            frame_err <= 1'b1;
            miso_reg  <= 1'b0;
            state     <= IDLE;
          end else if (sclk_rise) begin
            shift_in <= {shift_in[14:0], mosi_s[1]};
            bcnt     <= bcnt + 5'd1;
            if (bcnt == 5'd15) begin
              miso_reg <= 1'b0;
              state    <= DONE;
            end
          end else if (sclk_fall && bcnt != 5'd0) begin
            // MSB was presented at ss fall; the first falling edge before
            // any rising edge must not skip it.
            shift_out <= {shift_out[14:0], 1'b0};
            miso_reg  <= shift_out[14];
          end
        end

        DONE: begin
          if (ss_rise) begin
            last_cmd    <= shift_in;
            frame_count <= frame_count + 16'd1;
            if (shift_in[15:12] == 4'b0001 && shift_in[11]) begin
              prog_ch <= shift_in[8:7];
            end
            miso_reg <= 1'b0;
            state    <= IDLE;
          end
        end

        default: begin
          miso_reg <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ads7950_spi_responder.sv
// Randomized bench for ads7950_spi_responder with a frame-level reference model.
// Ports: drives the SPI interface as master, chan_data and rst; observes all outputs.
// Model tracks held capture, programmed channel, last command, frame and abort counts.
module tb_ads7950_spi_responder;

  logic        clk;
  logic        rst;
  logic [47:0] chan_data;
  logic [15:0] last_cmd;
  logic [15:0] frame_count;
  logic        frame_err;
  logic [1:0]  prog_ch;

  ads7950_spi_responder_if spi_bus ();

  ads7950_spi_responder #(.NCH(4), .DW(12)) dut (
    .clk         (clk),
    .rst         (rst),
    .spi         (spi_bus),
    .chan_data   (chan_data),
    .last_cmd    (last_cmd),
    .frame_count (frame_count),
    .frame_err   (frame_err),
    .prog_ch     (prog_ch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int err_seen = 0;

  // Reference model state.
  logic [11:0] chan [4];
  logic [15:0] m_held;
  logic [1:0]  m_prog;
  logic [15:0] m_last;
  logic [15:0] m_cnt;
  int          m_errs;

  always @(negedge clk) begin
    if (frame_err) err_seen++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_chan();
    chan_data = {chan[3], chan[2], chan[1], chan[0]};
  endtask

  task automatic model_reset();
    m_held = 16'h0000;
    m_prog = 2'd0;
    m_last = 16'h0000;
    m_cnt  = 16'h0000;
  endtask

  task automatic check_status();
    chk("last_cmd", {16'h0, last_cmd}, {16'h0, m_last});
    chk("frame_count", {16'h0, frame_count}, {16'h0, m_cnt});
    chk("prog_ch", {30'h0, prog_ch}, {30'h0, m_prog});
    chk("frame_err_pulses", err_seen, m_errs);
  endtask

  // One master frame with n rising sclk edges; miso sampled just before each rise.
  task automatic run_frame(input logic [15:0] cmd, input int n);
    logic [15:0] rx;
    logic [15:0] exp_rx;
    rx = 16'h0000;
    exp_rx = m_held;
    m_held = {2'b00, m_prog, chan[m_prog]};
    spi_bus.mosi = cmd[15];
    spi_bus.ss = 1'b0;
    wait_clk(4);
    for (int i = 0; i < n; i++) begin
      if (i < 16) rx[15-i] = spi_bus.miso;
      spi_bus.sclk = 1'b1;
      wait_clk(4);
      spi_bus.sclk = 1'b0;
      spi_bus.mosi = (i < 15) ? cmd[14-i] : 1'b0;
      wait_clk(4);
    end
    spi_bus.ss = 1'b1;
    wait_clk(6);
    if (n >= 16) begin
      m_last = cmd;
      m_cnt = m_cnt + 16'd1;
      if (cmd[15:12] == 4'b0001 && cmd[11]) m_prog = cmd[8:7];
      chk("rx_word", {16'h0, rx}, {16'h0, exp_rx});
    end else begin
      m_errs++;
      if (n > 0) chk("rx_partial", {16'h0, rx >> (16 - n)}, {16'h0, exp_rx >> (16 - n)});
    end
    check_status();
  endtask

  initial begin
    logic [15:0] cmd;
    int n;
    logic [15:0] rx_dummy;

    rst = 1'b0;
    spi_bus.sclk = 1'b0;
    spi_bus.ss = 1'b1;
    spi_bus.mosi = 1'b0;
    chan[0] = 12'hAAA;
    chan[1] = 12'hBBB;
    chan[2] = 12'hCCC;
    chan[3] = 12'hDDD;
    load_chan();
    model_reset();
    m_errs = 0;
    wait_clk(4);
    chk("rst_miso", {31'h0, spi_bus.miso}, 32'h0);
    chk("rst_frame_err", {31'h0, frame_err}, 32'h0);
    check_status();
    rst = 1'b1;
    wait_clk(6);

    // First frame after reset, then pipeline latency of a channel program.
    run_frame(16'h0000, 16);
    run_frame(16'h1980, 16);
    run_frame(16'h0000, 16);
    run_frame(16'h0000, 16);
    run_frame(16'h0000, 16);

    // Non-manual mode and manual mode without program enable.
    run_frame(16'h2980, 16);
    run_frame(16'h1180, 16);

    // Abort after 9 edges, then a normal frame programming ch2.
    run_frame(16'h1900, 9);
    run_frame(16'h1900, 16);

    // Overclocked frame: only the first 16 bits count.
    run_frame(16'h1880, 20);
    run_frame(16'h0000, 16);

    // Randomized frames with occasional channel data changes while idle.
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        chan[$urandom_range(0, 3)] = 12'($urandom);
        load_chan();
      end
      cmd = 16'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        cmd[15:12] = 4'b0001;
        cmd[11] = 1'($urandom_range(0, 3) != 0);
      end
      case ($urandom_range(0, 5))
        0: n = $urandom_range(0, 15);
        1: n = $urandom_range(17, 20);
        default: n = 16;
      endcase
      run_frame(cmd, n);
    end

    // Frame counter wrap from 0xFFFF.
    force dut.frame_count = 16'hFFFF;
    #1;
    release dut.frame_count;
    m_cnt = 16'hFFFF;
    wait_clk(1);
    run_frame(16'h1A00, 16);
    chk("wrap_count", {16'h0, frame_count}, 32'h0);

    // Reset in the middle of a frame.
    rx_dummy = 16'h0000;
    spi_bus.mosi = 1'b1;
    spi_bus.ss = 1'b0;
    wait_clk(4);
    for (int i = 0; i < 16; i++) begin
      if (i == 5) begin
        rst = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_miso", {31'h0, spi_bus.miso}, 32'h0);
        chk("mid_rst_frame_err", {31'h0, frame_err}, 32'h0);
        check_status();
        wait_clk(2);
        rst = 1'b1;
      end
      if (i > 5) rx_dummy[15-i] = spi_bus.miso;
      spi_bus.sclk = 1'b1;
      wait_clk(4);
      spi_bus.sclk = 1'b0;
      spi_bus.mosi = ~spi_bus.mosi;
      wait_clk(4);
    end
    spi_bus.ss = 1'b1;
    wait_clk(6);
    chk("post_rst_miso_bits", {16'h0, rx_dummy}, 32'h0);
    check_status();

    // Normal operation resumes from reset state.
    run_frame(16'h1880, 16);
    run_frame(16'h0000, 16);
    run_frame(16'h0000, 16);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
